// File: rtl/pieo_sched_pkg.sv
// Shared definitions for the PIEO post-dequeue path.
// Contents:
//   send_state_e   : send FSM encoding (IDLE=0, SEND=1)
//   isNullElement  : detects all-ones elements and out-of-range queue IDs
//   satInc         : increment that sticks at the all-ones value of a width
package pieo_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } send_state_e;

  // Widest element and counter the helpers accept; callers zero-extend into these.
  localparam int unsigned MAX_ELEM_W = 32;
  localparam int unsigned MAX_CNT_W  = 32;

  // An element is null when every one of its elemW bits is set, or when its
  // queue-ID field (low idW bits) names a queue that does not exist.
  function automatic logic isNullElement(input logic [MAX_ELEM_W-1:0] elem,
                                         input int unsigned           elemW,
                                         input int unsigned           idW,
                                         input int unsigned           numQueues);
    logic                  allOnes;
    logic [MAX_ELEM_W-1:0] id;
    allOnes = 1'b1;
    id      = '0;
    for (int unsigned i = 0; i < MAX_ELEM_W; i++) begin
      if ((i < elemW) && !elem[i]) allOnes = 1'b0;
      if (i < idW) id[i] = elem[i];
    end
    return allOnes || (id >= MAX_ELEM_W'(numQueues));
  endfunction

  // Adds one unless the value already equals 2^width-1.
  function automatic logic [MAX_CNT_W-1:0] satInc(input logic [MAX_CNT_W-1:0] value,
                                                  input int unsigned          width);
    logic [MAX_CNT_W:0] maxVal;
    maxVal = ((MAX_CNT_W+1)'(1) << width) - (MAX_CNT_W+1)'(1);
    if ({1'b0, value} >= maxVal) return value;
    return value + 1'b1;
  endfunction

endpackage

// File: rtl/pieo_post_deq_id_fifo.sv
// Small synchronous FIFO holding prefetched queue IDs.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i, data_i  : write an ID (ignored when full unless popping too)
//   pop_i           : drop the head entry (ignored when empty)
//   head_o          : current head entry, valid while empty_o is low
//   count_o         : occupancy, 0..DEPTH
//   full_o, empty_o : occupancy flags
module pieo_post_deq_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH-1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem[rdPtr_q];

  // A push into a full FIFO is still fine when the head leaves in the same cycle.
  assign doPush = push_i & (~full_o | pop_i);
  assign doPop  = pop_i & ~empty_o;

  always_comb begin
    wrPtr_d = doPush ? nextPtr(wrPtr_q) : wrPtr_q;
    rdPtr_d = doPop  ? nextPtr(rdPtr_q) : rdPtr_q;
    count_d = count_q + CW'(doPush) - CW'(doPop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/pieo_post_deq_prefetch.sv
// Post-dequeue controller between the PIEO scheduler and the egress mux.
// Prefetches queue IDs while a packet streams, drops null/stale elements and
// aborts packets that overrun the watchdog.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   en_in                       : global enable for new requests and pops
//   pieo_ready, pieo_empty      : PIEO status
//   pieo_deq_valid/_element     : dequeue response
//   pieo_deq_trigger            : one-cycle dequeue request (registered)
//   fifo_tvalid, pe_tlast       : per-queue data available / end of packet
//   fifos_not_enq_flag          : enqueue tracker busy, blocks new requests
//   sel_out, en_out             : registered mux select and enable
//   null/stale_drop_cnt, timeout_cnt : saturating event counters
//   timeout_pulse               : one-cycle pulse on a watchdog abort
module pieo_post_deq_prefetch
  import pieo_sched_pkg::*;
#(
  parameter int NUM_QUEUES     = 3,
  parameter int ID_LOG         = $clog2(NUM_QUEUES),
  parameter int RANK_LOG       = 1,
  parameter int TIME_LOG       = 1,
  parameter int PREFETCH_DEPTH = 2,
  parameter int MAX_PKT_CYCLES = 0,
  parameter int CNT_W          = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en_in,
  input  logic                                pieo_ready,
  input  logic                                pieo_empty,
  input  logic                                pieo_deq_valid,
  input  logic [ID_LOG+RANK_LOG+TIME_LOG-1:0] pieo_deq_element,
  output logic                                pieo_deq_trigger,
  input  logic [NUM_QUEUES-1:0]               fifo_tvalid,
  input  logic [NUM_QUEUES-1:0]               pe_tlast,
  input  logic                                fifos_not_enq_flag,
  output logic [ID_LOG-1:0]                   sel_out,
  output logic                                en_out,
  output logic [CNT_W-1:0]                    null_drop_cnt,
  output logic [CNT_W-1:0]                    stale_drop_cnt,
  output logic [CNT_W-1:0]                    timeout_cnt,
  output logic                                timeout_pulse
);

  localparam int ELEM_W = ID_LOG + RANK_LOG + TIME_LOG;
  localparam int FCNT_W = $clog2(PREFETCH_DEPTH+1);
  localparam int OCC_W  = FCNT_W + 1;
  localparam int WDOG_W = (MAX_PKT_CYCLES > 1) ? $clog2(MAX_PKT_CYCLES) : 1;

  send_state_e       state_q, state_d;
  logic              trigger_q, trigger_d;
  logic              outstanding_q, outstanding_d;
  logic [ID_LOG-1:0] sel_q, sel_d;
  logic              en_q, en_d;
  logic              pulse_q, pulse_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [CNT_W-1:0]  nullCnt_q, nullCnt_d, staleCnt_q, staleCnt_d, timeoutCnt_q, timeoutCnt_d;

  logic              accept, elemNull, push, pop, issue;
  logic [ID_LOG-1:0] head;
  logic [FCNT_W-1:0] fifoCount;
  logic              fifoFull, fifoEmpty;
  logic [OCC_W-1:0]  occNext;
  logic              headValid, selTlast, wdogExpire;

  pieo_post_deq_id_fifo #(
    .DEPTH(PREFETCH_DEPTH),
    .WIDTH(ID_LOG)
  ) idFifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i (pieo_deq_element[ID_LOG-1:0]),
    .pop_i  (pop),
    .head_o (head),
    .count_o(fifoCount),
    .full_o (fifoFull),
    .empty_o(fifoEmpty)
  );

  // Responses only count while a request is outstanding; stray strobes are ignored.
  assign accept   = pieo_deq_valid & outstanding_q;
  assign elemNull = isNullElement(MAX_ELEM_W'(pieo_deq_element), ELEM_W, ID_LOG, NUM_QUEUES);
  assign push     = accept & ~elemNull & (~fifoFull | pop);

  // Occupancy as it will be after this cycle's push/pop, so a new request
  // never targets a slot that the in-flight response will consume.
  assign occNext = {1'b0, fifoCount} + OCC_W'(push) - OCC_W'(pop);
  assign issue   = pieo_ready & ~pieo_empty & ~fifos_not_enq_flag & en_in
                 & (~outstanding_q | accept)
                 & (occNext < OCC_W'(PREFETCH_DEPTH));

  always_comb begin
    trigger_d     = issue;
    outstanding_d = outstanding_q;
    if (issue)       outstanding_d = 1'b1;
    else if (accept) outstanding_d = 1'b0;
    nullCnt_d = nullCnt_q;
    if (accept && elemNull) nullCnt_d = CNT_W'(satInc(MAX_CNT_W'(nullCnt_q), CNT_W));
  end

  // Look up the per-queue flags for the FIFO head and the active select.
  always_comb begin
    headValid = 1'b0;
    selTlast  = 1'b0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (head  == ID_LOG'(q)) headValid = fifo_tvalid[q];
      if (sel_q == ID_LOG'(q)) selTlast  = pe_tlast[q];
    end
  end

  assign wdogExpire = (MAX_PKT_CYCLES != 0) && (wdog_q == WDOG_W'(MAX_PKT_CYCLES-1));

  // Send FSM: IDLE pops one ID per cycle; SEND waits for tlast or the watchdog.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    en_d         = en_q;
    pulse_d      = 1'b0;
    wdog_d       = wdog_q;
    staleCnt_d   = staleCnt_q;
    timeoutCnt_d = timeoutCnt_q;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty && en_in) begin
          pop = 1'b1;
          if (headValid) begin
            sel_d   = head;
            en_d    = 1'b1;
            wdog_d  = '0;
            state_d = ST_SEND;
          end else begin
            staleCnt_d = CNT_W'(satInc(MAX_CNT_W'(staleCnt_q), CNT_W));
          end
        end
      end
      ST_SEND: begin
        // tlast wins over a simultaneous watchdog expiry.
        if (selTlast) begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (wdogExpire) begin
          en_d         = 1'b0;
          pulse_d      = 1'b1;
          timeoutCnt_d = CNT_W'(satInc(MAX_CNT_W'(timeoutCnt_q), CNT_W));
          state_d      = ST_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      trigger_q     <= 1'b0;
      outstanding_q <= 1'b0;
      sel_q         <= '0;
      en_q          <= 1'b0;
      pulse_q       <= 1'b0;
      wdog_q        <= '0;
      nullCnt_q     <= '0;
      staleCnt_q    <= '0;
      timeoutCnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      trigger_q     <= trigger_d;
      outstanding_q <= outstanding_d;
      sel_q         <= sel_d;
      en_q          <= en_d;
      pulse_q       <= pulse_d;
      wdog_q        <= wdog_d;
      nullCnt_q     <= nullCnt_d;
      staleCnt_q    <= staleCnt_d;
      timeoutCnt_q  <= timeoutCnt_d;
    end
  end

  assign pieo_deq_trigger = trigger_q;
  assign sel_out          = sel_q;
  assign en_out           = en_q;
  assign timeout_pulse    = pulse_q;
  assign null_drop_cnt    = nullCnt_q;
  assign stale_drop_cnt   = staleCnt_q;
  assign timeout_cnt      = timeoutCnt_q;

endmodule

// File: tb/tb_pieo_post_deq_prefetch.sv
// Bench for pieo_post_deq_prefetch: a PIEO responder model feeds scripted
// elements, a sink model raises tlast after a per-queue length, and a monitor
// checks each packet window against a queue of expected packets.
module tb_pieo_post_deq_prefetch;

  localparam int NQ    = 3;
  localparam int IDW   = 2;
  localparam int EW    = 4;
  localparam int DEPTH = 2;
  localparam int MAXC  = 8;
  localparam int CW    = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en_in = 1'b0;
  logic           pieo_ready = 1'b0;
  logic           pieo_empty = 1'b1;
  logic           pieo_deq_valid = 1'b0;
  logic [EW-1:0]  pieo_deq_element = '0;
  logic           pieo_deq_trigger;
  logic [NQ-1:0]  fifo_tvalid = '0;
  logic [NQ-1:0]  pe_tlast = '0;
  logic           fifos_not_enq_flag = 1'b0;
  logic [IDW-1:0] sel_out;
  logic           en_out;
  logic [CW-1:0]  null_drop_cnt, stale_drop_cnt, timeout_cnt;
  logic           timeout_pulse;

  typedef struct {
    int sel;
    int len;
    int timedOut;
    int gap;
  } pktExp_t;

  pktExp_t       expQ[$];
  logic [EW-1:0] respList[$];
  int            compared = 0;
  int            mismatched = 0;
  int            trigCount = 0;
  int            pktLenQ[NQ];
  bit            pending = 1'b0;
  logic [EW-1:0] pendingElem = '0;
  int            base;

  pieo_post_deq_prefetch #(
    .NUM_QUEUES(NQ), .ID_LOG(IDW), .RANK_LOG(1), .TIME_LOG(1),
    .PREFETCH_DEPTH(DEPTH), .MAX_PKT_CYCLES(MAXC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_in(en_in),
    .pieo_ready(pieo_ready), .pieo_empty(pieo_empty),
    .pieo_deq_valid(pieo_deq_valid), .pieo_deq_element(pieo_deq_element),
    .pieo_deq_trigger(pieo_deq_trigger),
    .fifo_tvalid(fifo_tvalid), .pe_tlast(pe_tlast),
    .fifos_not_enq_flag(fifos_not_enq_flag),
    .sel_out(sel_out), .en_out(en_out),
    .null_drop_cnt(null_drop_cnt), .stale_drop_cnt(stale_drop_cnt),
    .timeout_cnt(timeout_cnt), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic reportFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: condition not met (t=%0t)", name, $time);
  endtask

  // Queue one element for the PIEO to return; expSel < 0 means no packet is expected.
  task automatic applyStimulus(input logic [EW-1:0] elem, input int expSel,
                               input int expLen, input int expTimeout, input int expGap);
    pktExp_t e;
    respList.push_back(elem);
    if (expSel >= 0) begin
      e.sel = expSel; e.len = expLen; e.timedOut = expTimeout; e.gap = expGap;
      expQ.push_back(e);
    end
  endtask

  task automatic waitEnRise(input string name, input int budget);
    int n = 0;
    while (!en_out && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!en_out) reportFail(name);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (!(respList.size() == 0 && !pending && !pieo_deq_valid && expQ.size() == 0 && !en_out)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      reportFail(name);
      expQ.delete();
      respList.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // PIEO model: answers each trigger one cycle later with the next scripted element.
  always @(negedge clk) begin
    if (!rst_n) begin
      pending        = 1'b0;
      pieo_deq_valid = 1'b0;
      pieo_empty     = 1'b1;
    end else begin
      pieo_deq_valid = 1'b0;
      if (pending) begin
        pieo_deq_valid   = 1'b1;
        pieo_deq_element = pendingElem;
        pending          = 1'b0;
      end
      if (pieo_deq_trigger) begin
        trigCount++;
        pendingElem = (respList.size() > 0) ? respList.pop_front() : '1;
        pending     = 1'b1;
      end
      pieo_empty = (respList.size() == 0);
    end
  end

  // Sink model: raises tlast on the pktLenQ[sel]-th enabled cycle (0 = never).
  int sendCnt = 0;
  always @(negedge clk) begin
    pe_tlast = '0;
    if (!rst_n || !en_out) begin
      sendCnt = 0;
    end else begin
      sendCnt++;
      if (sel_out < NQ && pktLenQ[sel_out] != 0 && sendCnt == pktLenQ[sel_out])
        pe_tlast[sel_out] = 1'b1;
    end
  end

  // Monitor: each en_out window is matched against the next expected packet.
  bit      prevEn = 1'b0;
  bit      haveCur = 1'b0;
  int      lenCnt = 0;
  int      lowCnt = 0;
  pktExp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      prevEn  = 1'b0;
      haveCur = 1'b0;
      lenCnt  = 0;
      lowCnt  = 0;
    end else begin
      if (en_out && !prevEn) begin
        if (expQ.size() == 0) begin
          haveCur = 1'b0;
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_packet: got sel_out=%0d, expected no packet", sel_out);
        end else begin
          cur     = expQ.pop_front();
          haveCur = 1'b1;
          checkOutput("pkt_sel", int'(sel_out), cur.sel);
          if (cur.gap >= 0) checkOutput("pkt_gap", lowCnt, cur.gap);
        end
        lenCnt = 1;
      end else if (en_out) begin
        lenCnt++;
      end else if (prevEn) begin
        if (haveCur) begin
          checkOutput("pkt_len", lenCnt, cur.len);
          checkOutput("pkt_timeout_pulse", int'(timeout_pulse), cur.timedOut);
        end
        haveCur = 1'b0;
        lowCnt  = 0;
      end else if (timeout_pulse) begin
        reportFail("stray_timeout_pulse");
      end
      if (!en_out) lowCnt++;
      prevEn = en_out;
    end
  end

  initial begin
    pktLenQ[0] = 2; pktLenQ[1] = 4; pktLenQ[2] = 4;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_trigger", int'(pieo_deq_trigger), 0);
    checkOutput("rst_en_out", int'(en_out), 0);
    checkOutput("rst_sel_out", int'(sel_out), 0);
    checkOutput("rst_null_cnt", int'(null_drop_cnt), 0);
    checkOutput("rst_stale_cnt", int'(stale_drop_cnt), 0);
    checkOutput("rst_timeout_cnt", int'(timeout_cnt), 0);
    checkOutput("rst_timeout_pulse", int'(timeout_pulse), 0);

    pieo_ready  = 1'b1;
    en_in       = 1'b1;
    fifo_tvalid = 3'b111;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic prefetch: two requests issued before the first packet ends
    $display("[TB] basic prefetch");
    base = trigCount;
    applyStimulus(4'b0001, 1, 4, 0, -1);
    applyStimulus(4'b0010, 2, 4, 0, 1);
    waitEnRise("basic_en_rise", 40);
    @(negedge clk);
    checkOutput("basic_triggers_before_tlast", trigCount - base, 2);
    waitDrain("basic_drain", 100);

    // Null elements are counted and never reach the mux
    $display("[TB] null elements");
    base = trigCount;
    applyStimulus(4'b1111, -1, 0, 0, -1);
    applyStimulus(4'b0011, -1, 0, 0, -1);
    waitDrain("null_drain", 60);
    checkOutput("null_drop_cnt", int'(null_drop_cnt), 2);
    checkOutput("null_triggers", trigCount - base, 2);

    // Stale ID: queue 0 has no data when its ID reaches the head
    $display("[TB] stale element");
    fifo_tvalid = 3'b110;
    pktLenQ[2] = 6; pktLenQ[1] = 3;
    applyStimulus(4'b0010, 2, 6, 0, -1);
    applyStimulus(4'b0000, -1, 0, 0, -1);
    applyStimulus(4'b0001, 1, 3, 0, 2);
    waitDrain("stale_drain", 100);
    checkOutput("stale_drop_cnt", int'(stale_drop_cnt), 1);
    fifo_tvalid = 3'b111;

    // Watchdog: abort after 8 cycles, then tlast exactly on cycle 8
    $display("[TB] watchdog");
    pktLenQ[1] = 0;
    applyStimulus(4'b0001, 1, MAXC, 1, -1);
    waitDrain("wdog_drain", 60);
    checkOutput("wdog_timeout_cnt", int'(timeout_cnt), 1);
    pktLenQ[1] = MAXC;
    applyStimulus(4'b0001, 1, MAXC, 0, -1);
    waitDrain("wdog_tlast_drain", 60);
    checkOutput("wdog_tlast_timeout_cnt", int'(timeout_cnt), 1);

    // Gating by fifos_not_enq_flag during SEND
    $display("[TB] gating");
    pktLenQ[1] = 7; pktLenQ[2] = 8; pktLenQ[0] = 2;
    applyStimulus(4'b0001, 1, 7, 0, -1);
    waitEnRise("gate_pkt1_rise", 40);
    fifos_not_enq_flag = 1'b1;
    applyStimulus(4'b0010, 2, 8, 0, -1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("gate_flag_no_trigger", int'(pieo_deq_trigger), 0);
    end
    fifos_not_enq_flag = 1'b0;
    @(negedge clk);
    checkOutput("gate_flag_resume_trigger", int'(pieo_deq_trigger), 1);
    while (en_out) @(negedge clk);
    waitEnRise("gate_pkt2_rise", 40);

    // Gating by en_in during SEND; the current packet still completes
    en_in = 1'b0;
    applyStimulus(4'b0000, 0, 2, 0, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("gate_en_no_trigger", int'(pieo_deq_trigger), 0);
    end
    en_in = 1'b1;
    @(negedge clk);
    checkOutput("gate_en_resume_trigger", int'(pieo_deq_trigger), 1);
    waitDrain("gate_drain", 100);

    // Asynchronous reset mid-packet with two IDs prefetched
    $display("[TB] reset mid-packet");
    pktLenQ[1] = 8;
    applyStimulus(4'b0001, 1, 8, 0, -1);
    applyStimulus(4'b0010, -1, 0, 0, -1);
    applyStimulus(4'b0000, -1, 0, 0, -1);
    waitEnRise("reset_pkt_rise", 40);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_en_out_async", int'(en_out), 0);
    expQ.delete();
    respList.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_reset_no_trigger", int'(pieo_deq_trigger), 0);
      checkOutput("post_reset_en_low", int'(en_out), 0);
    end
    checkOutput("post_reset_null_cnt", int'(null_drop_cnt), 0);
    checkOutput("post_reset_stale_cnt", int'(stale_drop_cnt), 0);
    checkOutput("post_reset_timeout_cnt", int'(timeout_cnt), 0);
    pktLenQ[2] = 4;
    applyStimulus(4'b0010, 2, 4, 0, -1);
    waitDrain("post_reset_drain", 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
